// File: rtl/block_feature_pkg.sv
// Shared encodings and width helpers for the block feature writer.
package block_feature_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_CAPTURE    = 2'd1,
    ST_DRAIN_LAST = 2'd2,
    ST_WAIT_MODEL = 2'd3
  } state_e;

  localparam int F_GRAY = 0;
  localparam int F_SKIN = 1;
  localparam int F_DARK = 2;
  localparam int DATA_W = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int p = 1; p < v; p = p * 2) r++;
    return r;
  endfunction

  // Index width that stays legal for single-entry arrays.
  function automatic int idx_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

  function automatic int gsum_w(input int lb);
    return 8 + 2 * lb;
  endfunction

  function automatic int cnt_w(input int lb);
    return 2 * lb + 1;
  endfunction

endpackage

// File: rtl/pixel_classifier.sv
// Stage 1: registers gray level, skin and dark flags plus block position
// and block-start / row-end markers for one pixel.
module pixel_classifier
  import block_feature_pkg::*;
#(
  parameter int FRAME_W       = 640,
  parameter int BLK           = 8,
  parameter int XW            = 7,
  parameter int YW            = 6,
  parameter int SKIN_R_MIN    = 48,
  parameter int SKIN_G_MIN    = 20,
  parameter int SKIN_B_MIN    = 10,
  parameter int SKIN_RG_DELTA = 15,
  parameter int DARK_TH       = 90
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  input  logic [9:0]    x_i,
  input  logic [9:0]    y_i,
  input  logic [7:0]    r8_i,
  input  logic [7:0]    g8_i,
  input  logic [7:0]    b8_i,
  output logic          vld_o,
  output logic          first_o,
  output logic          last_o,
  output logic [XW-1:0] bx_o,
  output logic [YW-1:0] by_o,
  output logic [7:0]    gray_o,
  output logic          skin_o,
  output logic          dark_o
);
  localparam int LB = clog2(BLK);

  logic [9:0] sum;
  logic [8:0] r9, g9, b9;
  logic       skin_d, dark_d, first_d, last_d;

  assign sum = {2'b0, r8_i} + {2'b0, g8_i} + {2'b0, b8_i};
  assign r9  = {1'b0, r8_i};
  assign g9  = {1'b0, g8_i};
  assign b9  = {1'b0, b8_i};

  assign skin_d = (r9 > 9'(SKIN_R_MIN)) && (g9 > 9'(SKIN_G_MIN)) &&
                  (b9 > 9'(SKIN_B_MIN)) && (r9 > g9 + 9'(SKIN_RG_DELTA)) &&
                  (r9 > b9);
  assign dark_d  = sum < 10'(DARK_TH);
  assign first_d = ((x_i & 10'(BLK-1)) == '0) && ((y_i & 10'(BLK-1)) == '0);
  assign last_d  = (x_i == 10'(FRAME_W-1)) && ((y_i & 10'(BLK-1)) == 10'(BLK-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_o   <= 1'b0;
      first_o <= 1'b0;
      last_o  <= 1'b0;
      bx_o    <= '0;
      by_o    <= '0;
      gray_o  <= '0;
      skin_o  <= 1'b0;
      dark_o  <= 1'b0;
    end else begin
      vld_o   <= valid_i;
      first_o <= first_d;
      last_o  <= last_d;
      bx_o    <= XW'(x_i >> LB);
      by_o    <= YW'(y_i >> LB);
      gray_o  <= 8'(sum / 10'd3);
      skin_o  <= skin_d;
      dark_o  <= dark_d;
    end
  end

endmodule

// File: rtl/block_feature_writer.sv
// Accumulates per-block gray/skin/dark features one block row at a time and
// drains each finished row to the SRAM feature planes, then hands off to the model.
module block_feature_writer
  import block_feature_pkg::*;
#(
  parameter int FRAME_W       = 640,
  parameter int FRAME_H       = 480,
  parameter int BLK           = 8,
  parameter int AW            = 16,
  parameter int BASE          = 5000,
  parameter int PLANE_STRIDE  = 5000,
  parameter int SKIN_R_MIN    = 48,
  parameter int SKIN_G_MIN    = 20,
  parameter int SKIN_B_MIN    = 10,
  parameter int SKIN_RG_DELTA = 15,
  parameter int DARK_TH       = 90
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              pix_valid,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic [9:0]        pix_r,
  input  logic [9:0]        pix_g,
  input  logic [9:0]        pix_b,
  output logic              sram_wren,
  output logic [AW-1:0]     sram_addr,
  output logic [DATA_W-1:0] sram_data,
  input  logic              sram_ready,
  output logic              model_start,
  input  logic              model_finish,
  output logic              busy,
  output logic              overflow,
  output logic [1:0]        state
);
  localparam int BLKS_X = FRAME_W / BLK;
  localparam int BLKS_Y = FRAME_H / BLK;
  localparam int LB     = clog2(BLK);
  localparam int XW     = idx_w(BLKS_X);
  localparam int YW     = idx_w(BLKS_Y);
  localparam int GW     = gsum_w(LB);
  localparam int CW     = cnt_w(LB);

  state_e state_q, state_d;
  logic   ovf_q, mstart_q;

  logic in_frame, start_hit, pix_take;
  assign in_frame  = pix_valid && (pix_x < 10'(FRAME_W)) && (pix_y < 10'(FRAME_H));
  assign start_hit = in_frame && (state_q == ST_IDLE) && enable &&
                     (pix_x == '0) && (pix_y == '0);
  assign pix_take  = in_frame && ((state_q == ST_CAPTURE) || start_hit);

  logic          s1_vld, s1_first, s1_last, s1_skin, s1_dark;
  logic [XW-1:0] s1_bx;
  logic [YW-1:0] s1_by;
  logic [7:0]    s1_gray;

  pixel_classifier #(
    .FRAME_W(FRAME_W), .BLK(BLK), .XW(XW), .YW(YW),
    .SKIN_R_MIN(SKIN_R_MIN), .SKIN_G_MIN(SKIN_G_MIN), .SKIN_B_MIN(SKIN_B_MIN),
    .SKIN_RG_DELTA(SKIN_RG_DELTA), .DARK_TH(DARK_TH)
  ) u_cls (
    .clk(clk), .rst(rst), .valid_i(pix_take), .x_i(pix_x), .y_i(pix_y),
    .r8_i(8'(pix_r >> 2)), .g8_i(8'(pix_g >> 2)), .b8_i(8'(pix_b >> 2)),
    .vld_o(s1_vld), .first_o(s1_first), .last_o(s1_last), .bx_o(s1_bx),
    .by_o(s1_by), .gray_o(s1_gray), .skin_o(s1_skin), .dark_o(s1_dark)
  );

  // Line accumulators (stage 2) and the shadow row being drained.
  logic [GW-1:0] gsum_q [BLKS_X];
  logic [CW-1:0] skc_q  [BLKS_X];
  logic [CW-1:0] dkc_q  [BLKS_X];
  logic [GW-1:0] gsum_sh_q [BLKS_X];
  logic [CW-1:0] skc_sh_q  [BLKS_X];
  logic [CW-1:0] dkc_sh_q  [BLKS_X];
  logic          copy_q;
  logic [YW-1:0] copy_by_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gsum_q    <= '{default: '0};
      skc_q     <= '{default: '0};
      dkc_q     <= '{default: '0};
      copy_q    <= 1'b0;
      copy_by_q <= '0;
    end else begin
      copy_q    <= s1_vld && s1_last;
      copy_by_q <= s1_by;
      if (s1_vld) begin
        if (s1_first) begin
          gsum_q[s1_bx] <= GW'(s1_gray);
          skc_q[s1_bx]  <= CW'(s1_skin);
          dkc_q[s1_bx]  <= CW'(s1_dark);
        end else begin
          gsum_q[s1_bx] <= gsum_q[s1_bx] + GW'(s1_gray);
          skc_q[s1_bx]  <= skc_q[s1_bx] + CW'(s1_skin);
          dkc_q[s1_bx]  <= dkc_q[s1_bx] + CW'(s1_dark);
        end
      end
    end
  end

  logic          drain_q;
  logic [1:0]    f_q;
  logic [XW-1:0] dbx_q;
  logic [YW-1:0] dby_q;
  logic          copy_go, acc, last_word;

  // The copy reads the accumulators one cycle after the row's last update.
  assign copy_go   = copy_q && !drain_q;
  assign acc       = drain_q && sram_ready;
  assign last_word = (f_q == 2'(F_DARK)) && (dbx_q == XW'(BLKS_X-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gsum_sh_q <= '{default: '0};
      skc_sh_q  <= '{default: '0};
      dkc_sh_q  <= '{default: '0};
      drain_q   <= 1'b0;
      f_q       <= '0;
      dbx_q     <= '0;
      dby_q     <= '0;
    end else if (copy_go) begin
      gsum_sh_q <= gsum_q;
      skc_sh_q  <= skc_q;
      dkc_sh_q  <= dkc_q;
      drain_q   <= 1'b1;
      f_q       <= '0;
      dbx_q     <= '0;
      dby_q     <= copy_by_q;
    end else if (acc) begin
      if (dbx_q == XW'(BLKS_X-1)) begin
        dbx_q <= '0;
        if (last_word) drain_q <= 1'b0;
        else           f_q     <= f_q + 2'd1;
      end else begin
        dbx_q <= dbx_q + XW'(1);
      end
    end
  end

  logic [DATA_W-1:0] word;
  logic [31:0]       addr_full;

  always_comb begin
    word = '0;
    case (f_q)
      2'(F_GRAY): word = DATA_W'(gsum_sh_q[dbx_q] >> (2*LB));
      2'(F_SKIN): word = DATA_W'(skc_sh_q[dbx_q]);
      default:    word = DATA_W'(dkc_sh_q[dbx_q]);
    endcase
  end

  assign addr_full = 32'(BASE) + 32'(f_q) * 32'(PLANE_STRIDE) +
                     32'(dby_q) * 32'(BLKS_X) + 32'(dbx_q);

  assign sram_wren = drain_q;
  assign sram_addr = drain_q ? AW'(addr_full) : '0;
  assign sram_data = drain_q ? word : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (start_hit) state_d = ST_CAPTURE;
      ST_CAPTURE:    if (copy_q && (copy_by_q == YW'(BLKS_Y-1))) state_d = ST_DRAIN_LAST;
      // !drain_q covers a final copy skipped while the previous drain ended.
      ST_DRAIN_LAST: if (!drain_q || (acc && last_word)) state_d = ST_WAIT_MODEL;
      ST_WAIT_MODEL: if (model_finish) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ovf_q    <= 1'b0;
      mstart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mstart_q <= (state_q == ST_DRAIN_LAST) && (state_d == ST_WAIT_MODEL);
      if ((state_q == ST_IDLE) && (state_d == ST_CAPTURE)) ovf_q <= 1'b0;
      else if (copy_q && drain_q)                          ovf_q <= 1'b1;
    end
  end

  assign model_start = mstart_q;
  assign busy        = (state_q != ST_IDLE);
  assign overflow    = ovf_q;
  assign state       = state_q;

endmodule

// File: tb/tb_block_feature_writer.sv
// Randomized frame bench for block_feature_writer with a per-block feature
// reference computed directly from the captured image.
module tb_block_feature_writer;
  localparam int W = 32, H = 16, B = 8, BX = W / B, BY = H / B;
  localparam int BASE = 100, PS = 16;

  logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, pix_valid = 1'b0;
  logic [9:0]  pix_x = '0, pix_y = '0, pix_r = '0, pix_g = '0, pix_b = '0;
  logic        sram_wren, sram_ready = 1'b1;
  logic [15:0] sram_addr, sram_data;
  logic        model_start, model_finish = 1'b0, busy, overflow;
  logic [1:0]  state;

  always #5 clk = ~clk;

  block_feature_writer #(
    .FRAME_W(W), .FRAME_H(H), .BLK(B), .AW(16), .BASE(BASE), .PLANE_STRIDE(PS)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .sram_wren(sram_wren), .sram_addr(sram_addr), .sram_data(sram_data),
    .sram_ready(sram_ready), .model_start(model_start),
    .model_finish(model_finish), .busy(busy), .overflow(overflow), .state(state)
  );

  int checks = 0, errors = 0;
  int img_r[H][W], img_g[H][W], img_b[H][W];
  logic [31:0] obs[$], expq[$];
  int ms_cnt = 0;
  logic stall_prev = 1'b0;
  logic [15:0] held_a = '0, held_d = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Write monitor: accepted words, model_start pulses, stall stability.
  always @(negedge clk) begin
    if (model_start) ms_cnt++;
    if (stall_prev && sram_wren && !rst) begin
      chk("hold_addr", 32'(sram_addr), 32'(held_a));
      chk("hold_data", 32'(sram_data), 32'(held_d));
    end
    if (sram_wren && sram_ready) obs.push_back({sram_addr, sram_data});
    stall_prev = sram_wren && !sram_ready;
    held_a = sram_addr;
    held_d = sram_data;
  end

  function automatic int feat(input int f, input int by, input int bx);
    int a, r, g, b, s;
    a = 0;
    for (int yy = by * B; yy < by * B + B; yy++)
      for (int xx = bx * B; xx < bx * B + B; xx++) begin
        r = img_r[yy][xx] / 4; g = img_g[yy][xx] / 4; b = img_b[yy][xx] / 4;
        s = r + g + b;
        if (f == 0)      a += s / 3;
        else if (f == 1) a += (r > 48 && g > 20 && b > 10 && r > g + 15 && r > b) ? 1 : 0;
        else             a += (s < 90) ? 1 : 0;
      end
    return (f == 0) ? a / (B * B) : a;
  endfunction

  task automatic build_exp(input int mask);
    expq.delete();
    for (int by = 0; by < BY; by++)
      if (mask[by])
        for (int f = 0; f < 3; f++)
          for (int bx = 0; bx < BX; bx++)
            expq.push_back({16'(BASE + f * PS + by * BX + bx), 16'(feat(f, by, bx))});
  endtask

  function automatic logic [31:0] obs_at(input int a);
    foreach (obs[i]) if (obs[i][31:16] == 16'(a)) return {16'h0, obs[i][15:0]};
    return 32'hFFFF_FFFF;
  endfunction

  task automatic cmp_writes(input string tag);
    chk({tag, "_count"}, obs.size(), expq.size());
    for (int i = 0; i < obs.size() && i < expq.size(); i++) chk(tag, obs[i], expq[i]);
  endtask

  task automatic fill_uniform(input int v);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin img_r[y][x] = v; img_g[y][x] = v; img_b[y][x] = v; end
  endtask

  task automatic fill_skin_block();
    fill_uniform(0);
    for (int y = B; y < 2 * B; y++)
      for (int x = 2 * B; x < 3 * B; x++) begin
        img_r[y][x] = 800; img_g[y][x] = 400; img_b[y][x] = 240;
      end
  endtask

  task automatic fill_random();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        case ($urandom_range(2))
          0: begin
            img_r[y][x] = $urandom_range(1023, 560);
            img_g[y][x] = $urandom_range(400, 60);
            img_b[y][x] = $urandom_range(300, 30);
          end
          1: begin
            img_r[y][x] = $urandom_range(100);
            img_g[y][x] = $urandom_range(100);
            img_b[y][x] = $urandom_range(100);
          end
          default: begin
            img_r[y][x] = $urandom_range(1023);
            img_g[y][x] = $urandom_range(1023);
            img_b[y][x] = $urandom_range(1023);
          end
        endcase
  endtask

  task automatic drive(input logic v, input int x, input int y, input int r, input int g, input int b);
    @(posedge clk); #1;
    pix_valid = v; pix_x = 10'(x); pix_y = 10'(y);
    pix_r = 10'(r); pix_g = 10'(g); pix_b = 10'(b);
  endtask

  // One frame; each line is followed by an off-screen pixel and a
  // non-valid skin-coloured pixel, both of which must be ignored.
  task automatic send_frame(input logic en);
    enable = en;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) drive(1'b1, x, y, img_r[y][x], img_g[y][x], img_b[y][x]);
      drive(1'b1, W + y, y, 800, 400, 240);
      drive(1'b0, 0, y, 800, 400, 240);
      if (y == 0 && en) begin
        chk("state_capture", 32'(state), 32'd1);
        chk("busy_capture", 32'(busy), 32'd1);
        chk("ovf_clear_on_start", 32'(overflow), 32'd0);
        enable = 1'b0;
      end
      if (y == 2 && en) begin
        @(posedge clk); #1 model_finish = 1'b1;
        @(posedge clk); #1 model_finish = 1'b0;
        chk("finish_ignored", 32'(state), 32'd1);
      end
    end
    pix_valid = 1'b0;
  endtask

  task automatic stall(input int cycles);
    int n;
    n = 0;
    while (!sram_wren && n < 2000) begin @(negedge clk); n++; end
    chk("stall_wren_seen", 32'(sram_wren), 32'd1);
    @(posedge clk); #1 sram_ready = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 sram_ready = 1'b1;
  endtask

  task automatic run_frame(input string tag, input int mask, input int stall_cyc);
    int base, n;
    base = ms_cnt;
    obs.delete();
    if (stall_cyc > 0) fork send_frame(1'b1); stall(stall_cyc); join
    else send_frame(1'b1);
    n = 0;
    while (ms_cnt == base && n < 3000) begin @(posedge clk); n++; end
    chk({tag, "_ms_seen"}, 32'(ms_cnt > base), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_ms_once"}, 32'(ms_cnt - base), 32'd1);
    chk({tag, "_wait_model"}, 32'(state), 32'd3);
    model_finish = 1'b1;
    @(posedge clk); #1 model_finish = 1'b0;
    chk({tag, "_idle"}, 32'(state), 32'd0);
    build_exp(mask);
    cmp_writes(tag);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wren", 32'(sram_wren), 0);
    chk("rst_addr", 32'(sram_addr), 0);
    chk("rst_data", 32'(sram_data), 0);
    chk("rst_mstart", 32'(model_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_state", 32'(state), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    fill_uniform(400);
    run_frame("uniform", 3, 0);
    chk("uni_gray_100", obs_at(100), 100);
    chk("uni_gray_107", obs_at(107), 100);
    chk("uni_skin_116", obs_at(116), 0);
    chk("uni_dark_139", obs_at(139), 0);

    fill_skin_block();
    run_frame("skin", 3, 0);
    chk("skin_122", obs_at(122), 64);
    chk("dark_138", obs_at(138), 0);
    chk("gray_106", obs_at(106), 120);
    chk("dark_black_132", obs_at(132), 64);

    fill_random();
    run_frame("rand", 3, 0);

    fill_random();
    run_frame("stall40", 3, 40);

    fill_random();
    run_frame("overflow", 1, 400);
    chk("ovf_sticky", 32'(overflow), 1);

    fill_random();
    run_frame("after_ovf", 3, 0);

    // Reset while a drain is stalled.
    fill_random();
    sram_ready = 1'b0;
    obs.delete();
    fork
      send_frame(1'b1);
      begin
        int n;
        n = 0;
        while (!sram_wren && n < 2000) begin @(negedge clk); n++; end
        chk("rst_wren_seen", 32'(sram_wren), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_wren", 32'(sram_wren), 0);
        chk("async_state", 32'(state), 0);
        chk("async_ovf", 32'(overflow), 0);
        obs.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        sram_ready = 1'b1;
      end
    join
    repeat (50) @(posedge clk);
    #1;
    chk("no_writes_after_rst", obs.size(), 0);
    chk("idle_after_rst", 32'(state), 0);

    fill_random();
    send_frame(1'b0);
    repeat (50) @(posedge clk);
    #1;
    chk("unarmed_no_writes", obs.size(), 0);
    chk("unarmed_idle", 32'(state), 0);

    fill_random();
    run_frame("post_rst", 3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
